ula_seq: RTL and testbench

Parametrised, registered successor to the combinational ULA. It accepts an operand pair and a 5-bit opcode over a valid/ready handshake, and returns a registered result with N/Z/C/V flags. Shifts by a variable amount are real. They run iteratively at one bit per cycle, or in a single cycle when the barrel shifter is enabled. The block sits between the register-file read stage and writeback in the processor datapath.

---
 rtl/ula_seq.sv | 130 +++++++++++++
 tb/tb_ula_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ula_seq: registered ALU (add/sub/logic/shift, valid/ready in and out, {N,Z,C,V} flags, illegal-opcode flag); ports clock/reset, in_valid/in_ready/a/b/opcode in, out_valid/out_ready/result/flags/illegal out; define ULA_BARREL_EN for single-cycle barrel shifts instead of the 1 bit/cycle shifter
module ula_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] x, y, lres, sres, w, res;
  logic [WIDTH:0] sum;
  logic [SHW-1:0] amt, cnt;
  logic [3:0] fl;
  logic ci, arith, shop, ill, shc, cbit, asr_q, c, acc, is_shift;
  assign amt = b[SHW-1:0];
  assign is_shift = opcode[4:1] == 4'b0100;
  assign in_ready = state == IDLE && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
`ifdef ULA_BARREL_EN
  localparam bit ITER = 1'b0;
  logic [WIDTH-1:0] lr, rr;
  logic lc, rc;
  assign {lc, lr} = {1'b0, a} << amt;
  assign {rr, rc} = $signed({a, 1'b0}) >>> amt;
  assign sres = opcode[0] ? rr : lr;
  assign shc = opcode[0] ? rc : lc;
`else
  localparam bit ITER = 1'b1;
  assign sres = '0;
  assign shc = 1'b0;
`endif
  always_comb begin
    x = a;
    y = b;
    ci = 1'b0;
    arith = 1'b0;
    shop = 1'b0;
    ill = 1'b0;
    lres = '0;
    case (opcode)
      5'b00000: arith = 1'b1;
      5'b00001: begin arith = 1'b1; ci = 1'b1; end
      5'b00011: begin arith = 1'b1; y = '0; ci = 1'b1; end
      5'b00100: begin arith = 1'b1; y = ~b; end
      5'b00101: begin arith = 1'b1; y = ~b; ci = 1'b1; end
      5'b00110: begin arith = 1'b1; y = '1; end
      5'b01000, 5'b01001: shop = 1'b1;
      5'b10000: lres = '0;
      5'b10001: lres = a & b;
      5'b10010: lres = ~a & b;
      5'b10011: lres = b;
      5'b10100: lres = a & ~b;
      5'b10101: lres = a;
      5'b10110: lres = a ^ b;
      5'b10111: lres = a | b;
      5'b11000: lres = ~a & ~b;
      5'b11001: lres = ~(a ^ b);
      5'b11010: lres = ~a;
      5'b11011: lres = ~a | b;
      5'b11100: lres = ~b;
      5'b11101: lres = a | ~b;
      5'b11110: lres = ~a | ~b;
      5'b11111: lres = '1;
      default: ill = 1'b1;
    endcase
  end
  assign res = arith ? sum[WIDTH-1:0] : shop ? sres : lres;
  assign c = arith ? sum[WIDTH] : shop && shc;
  assign fl = ill ? 4'b0 : {res[WIDTH-1], res == '0, c,
                            arith && x[WIDTH-1] == y[WIDTH-1] && sum[WIDTH-1] != x[WIDTH-1]};
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
      illegal <= 1'b0;
      cnt <= '0;
      w <= '0;
      cbit <= 1'b0;
      asr_q <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (acc && is_shift && ITER) begin
            w <= a;
            cnt <= amt;
            cbit <= 1'b0;
            asr_q <= opcode[0];
            out_valid <= 1'b0;
            state <= SHIFT;
          end else if (acc) begin
            result <= res;
            flags <= fl;
            illegal <= ill;
            out_valid <= 1'b1;
          end else if (out_ready) out_valid <= 1'b0;
        SHIFT:
          if (cnt == '0) begin
            result <= w;
            flags <= {w[WIDTH-1], w == '0, cbit, 1'b0};
            illegal <= 1'b0;
            out_valid <= 1'b1;
            state <= HOLD;
          end else begin
            cbit <= asr_q ? w[0] : w[WIDTH-1];
            w <= asr_q ? {w[WIDTH-1], w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
            cnt <= cnt - 1'b1;
          end
        default:
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed scoreboard bench for ula_seq
module tb_ula_seq;
  localparam int W = 32;
`ifdef ULA_BARREL_EN
  localparam bit BAR = 1'b1;
`else
  localparam bit BAR = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, illegal;
  logic [W-1:0] a = '0, b = '0, result;
  logic [4:0] opcode = '0;
  logic [3:0] flags;
  typedef struct {
    string tag;
    logic [W-1:0] r;
    logic [3:0] f;
    logic i;
    int lat;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, t0 = 0;
  ula_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .illegal(illegal)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic issue(input string tag, input logic [4:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input bit push, input logic [W-1:0] er,
                       input logic [3:0] ef, input logic ei, input int lat);
    int n = 0;
    if (push) sb.push_back('{tag, er, ef, ei, lat});
    opcode = op;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_ready"}, in_ready, 1);
    t0 = cyc;
    @(negedge clock);
    in_valid = 1'b0;
  endtask
  task automatic collect();
    exp_t e;
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_valid"}, out_valid, 1);
      if (e.lat >= 0) chk({e.tag, "_lat"}, cyc - t0, e.lat);
      chk({e.tag, "_result"}, result, e.r);
      chk({e.tag, "_flags"}, flags, e.f);
      chk({e.tag, "_illegal"}, illegal, e.i);
    end
    @(negedge clock);
  endtask
  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_illegal", illegal, 0);
    issue("add_ovf", 5'b00000, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 4'b1001, 0, 1);
    collect();
    issue("sub_eq", 5'b00101, 32'd5, 32'd5, 1, 32'h0, 4'b0110, 0, 1);
    collect();
    issue("subdec", 5'b00100, 32'd0, 32'd0, 1, 32'hFFFFFFFF, 4'b1000, 0, 1);
    collect();
    issue("inca_wrap", 5'b00011, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 4'b0110, 0, 1);
    collect();
    issue("deca_zero", 5'b00110, 32'h0, 32'h0, 1, 32'hFFFFFFFF, 4'b1000, 0, 1);
    collect();
    issue("asr4", 5'b01001, 32'h80000010, 32'd4, 1, 32'hF8000001, 4'b1000, 0, BAR ? 1 : 6);
    collect();
    issue("lsl1", 5'b01000, 32'h80000001, 32'h21, 1, 32'h00000002, 4'b0010, 0, BAR ? 1 : 3);
    collect();
    issue("asr0", 5'b01001, 32'h80000000, 32'h0, 1, 32'h80000000, 4'b1000, 0, BAR ? 1 : 2);
    collect();
    issue("andn", 5'b10100, 32'hFF00FF00, 32'h0F0F0F0F, 1, 32'hF000F000, 4'b1000, 0, 1);
    collect();
    out_ready = 1'b0;
    issue("ones_bp", 5'b11111, 32'h0, 32'h0, 1, 32'hFFFFFFFF, 4'b1000, 0, -1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 32'hFFFFFFFF);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    collect();
    issue("add_2_3", 5'b00000, 32'd2, 32'd3, 1, 32'd5, 4'b0000, 0, 1);
    collect();
    issue("lsl20_rst", 5'b01000, 32'h1, 32'd20, 0, 32'h0, 4'b0, 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    issue("add_1_1", 5'b00000, 32'd1, 32'd1, 1, 32'd2, 4'b0000, 0, 1);
    collect();
    issue("undef", 5'b00010, 32'd7, 32'd9, 1, 32'h0, 4'b0000, 1, 1);
    collect();
    issue("xor", 5'b10110, 32'hF0F0F0F0, 32'hFFFF0000, 1, 32'h0F0FF0F0, 4'b0000, 0, 1);
    collect();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
